// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin arbiter for two buffered requesters writing a five-entry control register file
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   a_valid/a_ready/a_addr/a_data  requester A (SPI) write handshake
//   b_valid/b_ready/b_addr/b_data  requester B (sequencer/debug) write handshake
//   en_reg_out_*, en_reg_pwm_*, pwm_duty_cycle  registers 0x00..0x04
//   wr_commit, wr_src           one-cycle commit pulse and its source (0=A, 1=B)
//   bad_addr_cnt                saturating count of drained out-of-range writes
module reg_write_arbiter #(
  parameter int NUM_REGS = 5,
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic [DATA_W-1:0] en_reg_out_7_0,
  output logic [DATA_W-1:0] en_reg_out_15_8,
  output logic [DATA_W-1:0] en_reg_pwm_7_0,
  output logic [DATA_W-1:0] en_reg_pwm_15_8,
  output logic [DATA_W-1:0] pwm_duty_cycle,
  output logic              wr_commit,
  output logic              wr_src,
  output logic [7:0]        bad_addr_cnt
);
  logic              a_full_q, a_full_d, b_full_q, b_full_d;
  logic [ADDR_W-1:0] a_addr_q, a_addr_d, b_addr_q, b_addr_d;
  logic [DATA_W-1:0] a_data_q, a_data_d, b_data_q, b_data_d;
  logic              last_b_q, last_b_d;
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic              wr_commit_q, wr_commit_d, wr_src_q, wr_src_d;
  logic [7:0]        bad_q, bad_d;
  logic              gnt_a, gnt_b, drain, in_range, hit, miss, a_acc, b_acc;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;

  assign a_ready         = !a_full_q;
  assign b_ready         = !b_full_q;
  assign en_reg_out_7_0  = regs_q[0];
  assign en_reg_out_15_8 = regs_q[1];
  assign en_reg_pwm_7_0  = regs_q[2];
  assign en_reg_pwm_15_8 = regs_q[3];
  assign pwm_duty_cycle  = regs_q[4];
  assign wr_commit       = wr_commit_q;
  assign wr_src          = wr_src_q;
  assign bad_addr_cnt    = bad_q;

  always_comb begin
    // On a tie A wins only when B was served last.
    gnt_a    = a_full_q && (!b_full_q || last_b_q);
    gnt_b    = b_full_q && !gnt_a;
    drain    = gnt_a || gnt_b;
    w_addr   = gnt_b ? b_addr_q : a_addr_q;
    w_data   = gnt_b ? b_data_q : a_data_q;
    // Full-width compare so high addresses never alias onto implemented registers.
    in_range = w_addr < ADDR_W'(NUM_REGS);
    hit      = drain && in_range;
    miss     = drain && !in_range;
    // A buffer is only refilled while empty, so it can never drain and refill on one edge.
    a_acc    = a_valid && !a_full_q;
    b_acc    = b_valid && !b_full_q;
    a_full_d = a_acc || (a_full_q && !gnt_a);
    b_full_d = b_acc || (b_full_q && !gnt_b);
    a_addr_d = a_acc ? a_addr : a_addr_q;
    a_data_d = a_acc ? a_data : a_data_q;
    b_addr_d = b_acc ? b_addr : b_addr_q;
    b_data_d = b_acc ? b_data : b_data_q;
    last_b_d = drain ? gnt_b : last_b_q;
    for (int i = 0; i < NUM_REGS; i++)
      regs_d[i] = (hit && w_addr == ADDR_W'(i)) ? w_data : regs_q[i];
    wr_commit_d = hit;
    wr_src_d    = hit ? gnt_b : wr_src_q;
    bad_d       = (miss && bad_q != 8'hFF) ? bad_q + 8'd1 : bad_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_full_q    <= 1'b0;
      b_full_q    <= 1'b0;
      a_addr_q    <= '0;
      a_data_q    <= '0;
      b_addr_q    <= '0;
      b_data_q    <= '0;
      last_b_q    <= 1'b1;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      wr_commit_q <= 1'b0;
      wr_src_q    <= 1'b0;
      bad_q       <= '0;
    end else begin
      a_full_q    <= a_full_d;
      b_full_q    <= b_full_d;
      a_addr_q    <= a_addr_d;
      a_data_q    <= a_data_d;
      b_addr_q    <= b_addr_d;
      b_data_q    <= b_data_d;
      last_b_q    <= last_b_d;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
      wr_commit_q <= wr_commit_d;
      wr_src_q    <= wr_src_d;
      bad_q       <= bad_d;
    end
  end
endmodule
